// File: rtl/ula_multdiv.sv
// ALU with sequential signed MULT/DIV into HI/LO (one radix-2 step per cycle).
// Ports: clk, rst_n, valid, ULAopcode, A, B -> Result, Zero, Overflow, Stall, Done.
module ula_multdiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [3:0]  ULAopcode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Overflow,
    output logic        Stall,
    output logic        Done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_MFLO = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1011;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [31:0] acc_hi, acc_lo, opd;
    logic [4:0]  cnt;
    logic        is_div, neg_q, neg_r, div0;

    logic        start;
    logic [31:0] sum_ab, dif_ab;

    // one multiply step: conditional add then shift the 64-bit pair right
    logic [32:0] mul_sum;
    logic [31:0] mul_hi, mul_lo;

    // one restoring-divide step: shift dividend bit into remainder, trial subtract
    logic [32:0] r_sh, r_diff;
    logic        r_ge;
    logic [31:0] div_hi, div_lo;

    // sign-corrected results, valid in DONE
    logic [63:0] prod, prod_s;
    logic [31:0] quo_s, rem_s;

    assign start  = valid && (ULAopcode == OP_MULT || ULAopcode == OP_DIV);
    assign Stall  = (state == IDLE && start) || state == RUN;
    assign Done   = (state == DONE);

    assign sum_ab = A + B;
    assign dif_ab = A - B;

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : 33'd0);
    assign mul_hi  = mul_sum[32:1];
    assign mul_lo  = {mul_sum[0], acc_lo[31:1]};

    assign r_sh   = {acc_hi, acc_lo[31]};
    assign r_diff = r_sh - {1'b0, opd};
    assign r_ge   = ~r_diff[32];
    assign div_hi = r_ge ? r_diff[31:0] : r_sh[31:0];
    assign div_lo = {acc_lo[30:0], r_ge};

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_q ? (64'd0 - prod) : prod;
    // divide by zero leaves remainder = |A|, so HI comes out as A after sign fix
    assign quo_s  = div0 ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_lo) : acc_lo);
    assign rem_s  = neg_r ? (32'd0 - acc_hi) : acc_hi;

    always_comb begin
        Result   = 32'd0;
        Overflow = 1'b0;
        case (ULAopcode)
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            OP_ADD: begin
                Result   = sum_ab;
                Overflow = (A[31] == B[31]) && (sum_ab[31] != A[31]);
            end
            OP_SUB: begin
                Result   = dif_ab;
                Overflow = (A[31] != B[31]) && (dif_ab[31] != A[31]);
            end
            OP_SLT:  Result = {31'd0, $signed(A) < $signed(B)};
            OP_NOR:  Result = ~(A | B);
            OP_XOR:  Result = A ^ B;
            OP_LUI:  Result = {B[15:0], 16'h0000};
            OP_MFLO: Result = lo;
            OP_MFHI: Result = hi;
            default: Result = 32'd0;
        endcase
    end

    assign Zero = (Result == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= 32'd0;
            lo     <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            opd    <= 32'd0;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        acc_hi <= 32'd0;
                        acc_lo <= A[31] ? (32'd0 - A) : A;
                        opd    <= B[31] ? (32'd0 - B) : B;
                        cnt    <= 5'd31;
                        is_div <= (ULAopcode == OP_DIV);
                        neg_q  <= A[31] ^ B[31];
                        neg_r  <= A[31];
                        div0   <= (B == 32'd0);
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc_hi <= div_hi;
                        acc_lo <= div_lo;
                    end else begin
                        acc_hi <= mul_hi;
                        acc_lo <= mul_lo;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (is_div) begin
                        hi <= rem_s;
                        lo <= quo_s;
                    end else begin
                        hi <= prod_s[63:32];
                        lo <= prod_s[31:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multdiv.sv
// Self-checking bench for ula_multdiv: ALU vector table plus
// scoreboarded MULT/DIV sequences (latency, corner cases, reset abort).
module tb_ula_multdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  ULAopcode = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] Result;
    logic        Zero, Overflow, Stall, Done;

    localparam logic [3:0] MULT = 4'b1000;
    localparam logic [3:0] DIV  = 4'b1001;
    localparam logic [3:0] MFLO = 4'b1010;
    localparam logic [3:0] MFHI = 4'b1011;

    ula_multdiv dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ULAopcode(ULAopcode),
        .A(A), .B(B), .Result(Result), .Zero(Zero), .Overflow(Overflow),
        .Stall(Stall), .Done(Done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        st;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] pa, pb, p;
        logic signed [31:0] sa, sbv;
        sa  = a;
        sbv = b;
        if (op == MULT) begin
            pa = {{32{a[31]}}, a};
            pb = {{32{b[31]}}, b};
            p  = pa * pb;
            e  = p;
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
        end else begin
            e.lo = sa / sbv;
            e.hi = sa % sbv;
        end
        return e;
    endfunction

    // Issue one MULT/DIV, measure stall/done latency, then read LO and HI.
    task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input bit scramble,
                              input bit rel);
        int   stalls;
        int   done_cyc;
        exp_t e;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        valid     = 1'b1;
        ULAopcode = op;
        A         = a;
        B         = b;
        sb_q.push_back(model(op, a, b));
        stalls   = 0;
        done_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (Done) begin
                done_cyc = i + 1;
                check("stall_in_done", {63'd0, Stall}, 64'd0);
                break;
            end
            if (Stall) stalls++;
            if (scramble && i == 6) begin
                A         = $urandom;
                B         = $urandom;
                ULAopcode = 4'b0010;
            end
            @(negedge clk);
        end
        check("done_seen", {63'd0, done_cyc != 0}, 64'd1);
        check("stall_cycles", 64'(stalls), 64'd33);
        check("done_cycle", 64'(done_cyc), 64'd34);
        @(negedge clk);
        ULAopcode = MFLO;
        #1;
        e = sb_q.pop_front();
        check("mflo", {32'd0, Result}, {32'd0, e.lo});
        check("mflo_nostall", {63'd0, Stall}, 64'd0);
        @(negedge clk);
        ULAopcode = MFHI;
        #1;
        check("mfhi", {32'd0, Result}, {32'd0, e.hi});
        valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'b1110, 32'hDEAD, 32'h1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'b1101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'b0011, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b1000, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'b1010, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 4'b0010, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b0};

        #2;
        check("rst_stall", {63'd0, Stall}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        ULAopcode = MFHI;
        #1;
        check("rst_hi", {32'd0, Result}, 64'd0);
        ULAopcode = MFLO;
        #1;
        check("rst_lo", {32'd0, Result}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            valid     = vecs[i].v;
            ULAopcode = vecs[i].op;
            A         = vecs[i].a;
            B         = vecs[i].b;
            #1;
            check($sformatf("vec%0d_result", i), {32'd0, Result}, {32'd0, vecs[i].res});
            check($sformatf("vec%0d_zero", i), {63'd0, Zero}, {63'd0, vecs[i].z});
            check($sformatf("vec%0d_ovf", i), {63'd0, Overflow}, {63'd0, vecs[i].o});
            check($sformatf("vec%0d_stall", i), {63'd0, Stall}, {63'd0, vecs[i].st});
        end
        @(negedge clk);
        valid = 1'b0;

        run_muldiv(MULT, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b0);
        run_muldiv(DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
        run_muldiv(DIV, 32'h10, 32'h0, 1'b0, 1'b0);
        run_muldiv(DIV, 32'hFFFF_FFF6, 32'h0, 1'b0, 1'b0);
        run_muldiv(MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_muldiv(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_muldiv(DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF9, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_muldiv((i % 2 == 0) ? MULT : DIV, $urandom, $urandom, 1'b0, 1'b0);
        end
        run_muldiv(MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);

        // reset in the middle of a MULT, request held through release
        @(negedge clk);
        valid     = 1'b1;
        ULAopcode = MULT;
        A         = 32'hFFFF_FFFD;
        B         = 32'h7;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        check("abort_running", {63'd0, Stall}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_done", {63'd0, Done}, 64'd0);
        ULAopcode = MFHI;
        #1;
        check("abort_hi", {32'd0, Result}, 64'd0);
        ULAopcode = MFLO;
        #1;
        check("abort_lo", {32'd0, Result}, 64'd0);
        ULAopcode = MULT;
        #1;
        check("abort_idle_req", {63'd0, Stall}, 64'd1);
        run_muldiv(MULT, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_multdiv.md
ULA_MULTDIV -- requirements
Module: ula_multdiv

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  current instruction is valid
- ULAopcode  in  4  operation select from the ALU control decoder
- A  in  32  operand rs
- B  in  32  operand rt or extended immediate
- Result  out  32  combinational result
- Zero  out  1  Result == 0
- Overflow  out  1  signed overflow, ADD/SUB only
- Stall  out  1  hold PC and register write this cycle
- Done  out  1  one-cycle pulse when HI/LO are written

Function
REQ-003 Result SHALL be computed combinationally per ULAopcode:
- 0000 A&B
- 0001 A|B
- 0010 A+B
- 0110 A-B
- 0111 signed A<B ? 1 : 0
- 1100 ~(A|B)
- 1101 A^B
- 1110 {B[15:0],16'h0}
- 1010 LO
- 1011 HI
- 1000, 1001 and all other codes: 0
REQ-004 Overflow SHALL be 1 only for 0010/0110 with signed 32-bit overflow; 0 otherwise.
REQ-005 ULAopcode 1000 SHALL mean signed MULT ({HI,LO}=A*B); 1001 SHALL mean signed DIV (LO=A/B truncated toward zero, HI=remainder with sign of A).
REQ-006 The state machine SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-007 IDLE->RUN SHALL occur when valid=1 and ULAopcode is 1000 or 1001. At that edge the block SHALL latch |A|, |B|, the result signs and the op, and load a 5-bit counter with 31.
REQ-008 In RUN, one radix-2 iteration SHALL be performed per cycle (shift-add multiply or restoring divide, unsigned on magnitudes). The counter SHALL decrement; RUN->DONE SHALL occur on the edge where counter==0, giving exactly 32 RUN cycles.
REQ-009 In DONE, sign correction SHALL be applied, HI/LO SHALL be written at the edge leaving DONE, Done SHALL be 1, and DONE->IDLE SHALL occur unconditionally; no new start is accepted in DONE.
REQ-010 Stall SHALL be 1 when (state==IDLE and valid and ULAopcode in {1000,1001}) or state==RUN; otherwise 0. A MULT/DIV instruction is therefore held 33 cycles and retires in the DONE cycle (34th cycle).
REQ-011 MFLO/MFHI in the cycle after DONE SHALL return the newly written LO/HI.
REQ-012 HI/LO SHALL change only at the DONE edge; operand or ULAopcode changes during RUN SHALL be ignored.
REQ-013 Divide by zero SHALL complete in normal latency with LO=32'hFFFFFFFF, HI=A.
REQ-014 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-015 MULT magnitudes SHALL be handled as unsigned 32-bit values, so |-2^31| = 32'h80000000 with no saturation.

Reset
REQ-016 With rst_n=0, regardless of clock: state=IDLE, HI=LO=0, counter and internal accumulators=0, Done=0, Stall=0 (absent a valid MULT/DIV request).
REQ-017 Reset asserted mid-RUN SHALL abort the operation with no HI/LO update. After release, the block SHALL start a fresh operation if the MULT/DIV request is still present.

Verification
REQ-018 ADD 7FFFFFFF+1: Result=80000000, Overflow=1, Zero=0. SUB 5-5: Result=0, Zero=1. SLT FFFFFFFF,1: Result=1. LUI B=1234: Result=12340000.
REQ-019 MULT A=FFFFFFFD(-3), B=7: Stall=1 for 33 cycles, Done pulse on the 34th. Then MFHI=FFFFFFFF, MFLO=FFFFFFEB.
REQ-020 DIV A=FFFFFFF9(-7), B=2: LO=FFFFFFFD(-3), HI=FFFFFFFF(-1). DIV A=10, B=0: LO=FFFFFFFF, HI=10.
REQ-021 MULT 80000000*80000000: HI=40000000, LO=0. DIV 80000000/FFFFFFFF: LO=80000000, HI=0.
REQ-022 Start MULT, pulse rst_n low at RUN cycle 10: HI=LO=0 and state IDLE. With request held after release, a full 33-cycle stall repeats and correct results are written.
REQ-023 Change A/B mid-RUN: HI/LO reflect the operands latched at start. Back-to-back MULT then MFLO: correct LO with no extra stall.
